// File: rtl/dance_pkg.sv
// Shared constants for the dandy-dance frame sequencer: FSM state codes,
// playback mode encodings and frame geometry.
package dance_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NUM_FRAMES = 8;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_PLAY  = 2'd1;
    localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_ONCE     = 2'b00;
    localparam logic [1:0] MODE_LOOP     = 2'b01;
    localparam logic [1:0] MODE_PING     = 2'b10;
    localparam logic [1:0] MODE_LOOP_ALT = 2'b11;

    localparam logic [SEG_W-1:0] BLANK    = 7'h00;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

endpackage

// File: rtl/dance_frame_rom.sv
// Eight-entry animation ROM: a single segment sweeping a..g, then a,d,g together.
module dance_frame_rom
    import dance_pkg::*;
(
    input  logic [2:0] idx,
    output logic [6:0] pattern_c
);

    always_comb begin
        pattern_c = BLANK;
        case (idx)
            3'd0:    pattern_c = 7'h01;
            3'd1:    pattern_c = 7'h02;
            3'd2:    pattern_c = 7'h04;
            3'd3:    pattern_c = 7'h08;
            3'd4:    pattern_c = 7'h10;
            3'd5:    pattern_c = 7'h20;
            3'd6:    pattern_c = 7'h40;
            default: pattern_c = 7'h49;
        endcase
    end

endmodule

// File: rtl/dance_sequencer.sv
// Frame scheduler for the seven-segment dance animation: once/loop/ping-pong
// playback at a programmable frame period with start/stop/pause control.
module dance_sequencer
    import dance_pkg::*;
#(
    parameter int unsigned TICK_SHIFT = 16,
    parameter int unsigned PRESC_W    = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic [3:0] speed,
    output logic [6:0] segments,
    output logic [2:0] frame_idx,
    output logic       busy,
    output logic       done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] period_m1;
    logic [1:0]         mode_q, mode_d;
    logic [3:0]         speed_q, speed_d;
    logic               dir_q, dir_d;
    logic [IDX_W-1:0]   idx_d;
    logic [SEG_W-1:0]   seg_d;
    logic [SEG_W-1:0]   rom_seg;
    logic               busy_d;
    logic               done_d;
    logic               tick;

    // Last prescaler value of a frame; frame lasts (speed_q+1) << TICK_SHIFT cycles.
    assign period_m1 = PRESC_W'((PRESC_W'(speed_q) + PRESC_W'(1)) << TICK_SHIFT) - PRESC_W'(1);
    assign tick      = (presc_q == period_m1);

    dance_frame_rom u_rom (
        .idx       (idx_d),
        .pattern_c (rom_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            mode_q    <= MODE_ONCE;
            speed_q   <= '0;
            dir_q     <= 1'b0;
            frame_idx <= '0;
            segments  <= BLANK;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            dir_q     <= dir_d;
            frame_idx <= idx_d;
            segments  <= seg_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next state; priority stop > start > pause > tick. dir_q=1 means counting down.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        idx_d   = frame_idx;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                    presc_d = '0;
                    idx_d   = '0;
                    dir_d   = 1'b0;
                    mode_d  = mode;
                    speed_d = speed;
                end
            end
            ST_PLAY, ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    idx_d   = '0;
                    dir_d   = 1'b0;
                end else if (start) begin
                    state_d = ST_PLAY;
                    presc_d = '0;
                    idx_d   = '0;
                    dir_d   = 1'b0;
                    mode_d  = mode;
                    speed_d = speed;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    // Resume edge also counts, so a pause of N cycles stretches the frame by N.
                    state_d = ST_PLAY;
                    if (tick) begin
                        presc_d = '0;
                        speed_d = speed;
                        case (mode_q)
                            MODE_ONCE: begin
                                if (frame_idx == LAST_IDX) begin
                                    state_d = ST_DONE;
                                    idx_d   = '0;
                                    done_d  = 1'b1;
                                end else begin
                                    idx_d = IDX_W'(frame_idx + 1'b1);
                                end
                            end
                            MODE_PING: begin
                                if (!dir_q) begin
                                    if (frame_idx == LAST_IDX) begin
                                        idx_d = IDX_W'(LAST_IDX - 1'b1);
                                        dir_d = 1'b1;
                                    end else begin
                                        idx_d = IDX_W'(frame_idx + 1'b1);
                                    end
                                end else begin
                                    if (frame_idx == '0) begin
                                        idx_d = IDX_W'(1);
                                        dir_d = 1'b0;
                                    end else begin
                                        idx_d = IDX_W'(frame_idx - 1'b1);
                                    end
                                end
                            end
                            MODE_LOOP, MODE_LOOP_ALT: idx_d = IDX_W'(frame_idx + 1'b1);
                            default:                  idx_d = IDX_W'(frame_idx + 1'b1);
                        endcase
                    end else begin
                        presc_d = PRESC_W'(presc_q + PRESC_W'(1));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Display only while an animation is active; blank otherwise.
    always_comb begin
        busy_d = (state_d == ST_PLAY) || (state_d == ST_PAUSE);
        seg_d  = busy_d ? rom_seg : BLANK;
    end

endmodule

// File: tb/tb_dance_sequencer.sv
// Directed scoreboard bench for dance_sequencer with TICK_SHIFT=2 (4-cycle base frame).
module tb_dance_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start;
    logic       stop;
    logic       pause;
    logic [1:0] mode;
    logic [3:0] speed;
    logic [6:0] segments;
    logic [2:0] frame_idx;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [6:0] rom_tbl[8];
    int         pp_seq[16];

    dance_sequencer #(
        .TICK_SHIFT (2),
        .PRESC_W    (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .mode      (mode),
        .speed     (speed),
        .segments  (segments),
        .frame_idx (frame_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input logic [6:0] s, input logic [2:0] i, input logic b, input logic d);
        obs_t e;
        e = '{seg: s, idx: i, busy: b, done: d};
        sb.push_back(e);
    endtask

    // One clock edge, then compare the DUT against the oldest expectation.
    task automatic step(input string tag);
        obs_t got;
        obs_t exp;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        got   = obs_t'({segments, frame_idx, busy, done});
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s no expectation queued got seg=%h idx=%0d", tag, got.seg, got.idx);
        end else begin
            exp = sb.pop_front();
            assert (got === exp) else begin
                failures++;
                $error("FAIL %s got seg=%h idx=%0d busy=%b done=%b exp seg=%h idx=%0d busy=%b done=%b",
                       tag, got.seg, got.idx, got.busy, got.done,
                       exp.seg, exp.idx, exp.busy, exp.done);
            end
        end
    endtask

    task automatic play(input int k, input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            expect_out(rom_tbl[k], 3'(k), 1'b1, 1'b0);
            step(tag);
        end
    endtask

    task automatic idle_check(input string tag);
        expect_out(7'h00, 3'd0, 1'b0, 1'b0);
        step(tag);
    endtask

    initial begin
        rom_tbl = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h49};
        pp_seq  = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        rst   = 1'b1;
        ena   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        mode  = 2'b00;
        speed = 4'd0;

        idle_check("reset");
        idle_check("reset_hold");
        rst = 1'b0;
        idle_check("idle");

        // Play-once: each frame 4 cycles, then a single done pulse.
        mode  = 2'b00;
        speed = 4'd0;
        start = 1'b1;
        for (int k = 0; k < 8; k++) play(k, 4, "once_frame");
        expect_out(7'h00, 3'd0, 1'b0, 1'b1);
        step("once_done");
        idle_check("once_after_done");

        // Loop at speed 1: 8 cycles per frame, wrap to frame 0 without done.
        mode  = 2'b01;
        speed = 4'd1;
        start = 1'b1;
        for (int k = 0; k < 8; k++) play(k, 8, "loop_frame");
        play(0, 8, "loop_wrap");
        play(1, 1, "loop_wrap_next");
        stop = 1'b1;
        idle_check("loop_stop");

        // Ping-pong: endpoints shown once per reversal.
        mode  = 2'b10;
        speed = 4'd0;
        start = 1'b1;
        for (int i = 0; i < 16; i++) play(pp_seq[i], 4, "ping_frame");
        stop = 1'b1;
        idle_check("ping_stop");

        // Pause for 10 cycles in frame 3, ena low for 5 cycles in frame 4.
        mode  = 2'b01;
        speed = 4'd0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) play(k, 4, "pause_lead");
        play(3, 2, "pause_pre");
        pause = 1'b1;
        play(3, 10, "pause_hold");
        pause = 1'b0;
        play(3, 2, "pause_post");
        play(4, 2, "ena_pre");
        ena = 1'b0;
        play(4, 5, "ena_low");
        ena = 1'b1;
        play(4, 2, "ena_post");

        // Stop on the same edge as the frame-5 tick.
        play(5, 4, "stop_frame5");
        stop = 1'b1;
        idle_check("stop_tick");
        idle_check("stop_no_done");

        // Restart mid-frame 5.
        mode  = 2'b01;
        start = 1'b1;
        for (int k = 0; k < 5; k++) play(k, 4, "restart_lead");
        play(5, 2, "restart_frame5");
        start = 1'b1;
        play(0, 4, "restart_frame0");
        play(1, 2, "restart_frame1");

        // Synchronous reset mid-play, then a fresh play-once start.
        rst = 1'b1;
        idle_check("rst_mid_play");
        rst = 1'b0;
        idle_check("rst_idle");
        mode  = 2'b00;
        speed = 4'd0;
        start = 1'b1;
        play(0, 4, "post_rst_frame0");
        play(1, 1, "post_rst_frame1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
